// File: rtl/window5x5_gen.sv
// 5x5 sliding-window generator: turns a raster pixel stream into 25 parallel
// window taps using four line buffers and a 5x5 register array.
module window5x5_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [DATA_W-1:0]             pix1,
    output logic [DATA_W-1:0]             pix2,
    output logic [DATA_W-1:0]             pix3,
    output logic [DATA_W-1:0]             pix4,
    output logic [DATA_W-1:0]             pix5,
    output logic [DATA_W-1:0]             pix6,
    output logic [DATA_W-1:0]             pix7,
    output logic [DATA_W-1:0]             pix8,
    output logic [DATA_W-1:0]             pix9,
    output logic [DATA_W-1:0]             pix10,
    output logic [DATA_W-1:0]             pix11,
    output logic [DATA_W-1:0]             pix12,
    output logic [DATA_W-1:0]             pix13,
    output logic [DATA_W-1:0]             pix14,
    output logic [DATA_W-1:0]             pix15,
    output logic [DATA_W-1:0]             pix16,
    output logic [DATA_W-1:0]             pix17,
    output logic [DATA_W-1:0]             pix18,
    output logic [DATA_W-1:0]             pix19,
    output logic [DATA_W-1:0]             pix20,
    output logic [DATA_W-1:0]             pix21,
    output logic [DATA_W-1:0]             pix22,
    output logic [DATA_W-1:0]             pix23,
    output logic [DATA_W-1:0]             pix24,
    output logic [DATA_W-1:0]             pix25,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;

    // Line buffers: lb0 holds the previous line, lb3 the line four rows up.
    logic [DATA_W-1:0] lb0 [IMG_WIDTH];
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] lb3 [IMG_WIDTH];
    logic [DATA_W-1:0] rd0, rd1, rd2, rd3;

    // win[i][j]: i = row (0 oldest), j = column (0 oldest).
    logic [DATA_W-1:0] win [5][5];

    // Position of the pixel accepted this cycle; sof forces it to (0,0).
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign rd0 = lb0[cur_col];
    assign rd1 = lb1[cur_col];
    assign rd2 = lb2[cur_col];
    assign rd3 = lb3[cur_col];

    // Raster position counters; wrapping row lets frames run back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col <= '0;
                if (cur_row == ROW_W'(IMG_HEIGHT - 1)) begin
                    row <= '0;
                end else begin
                    row <= cur_row + ROW_W'(1);
                end
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    // Line-buffer chain: read-before-write shifts each column up one line.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb0[cur_col] <= pix_in;
            lb1[cur_col] <= rd0;
            lb2[cur_col] <= rd1;
            lb3[cur_col] <= rd2;
        end
    end

    // Window array: shift left, new column enters on the right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (pix_valid) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win[i][j] <= win[i][j+1];
                end
            end
            win[0][4] <= rd3;
            win[1][4] <= rd2;
            win[2][4] <= rd1;
            win[3][4] <= rd0;
            win[4][4] <= pix_in;
        end
    end

    // Window status: valid only for a fully in-frame window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= 1'b0;
            if (pix_valid) begin
                win_valid <= (cur_row >= ROW_W'(4)) && (cur_col >= COL_W'(4));
                win_row   <= cur_row;
                win_col   <= cur_col;
            end
        end
    end

    assign pix1  = win[0][0];
    assign pix2  = win[0][1];
    assign pix3  = win[0][2];
    assign pix4  = win[0][3];
    assign pix5  = win[0][4];
    assign pix6  = win[1][0];
    assign pix7  = win[1][1];
    assign pix8  = win[1][2];
    assign pix9  = win[1][3];
    assign pix10 = win[1][4];
    assign pix11 = win[2][0];
    assign pix12 = win[2][1];
    assign pix13 = win[2][2];
    assign pix14 = win[2][3];
    assign pix15 = win[2][4];
    assign pix16 = win[3][0];
    assign pix17 = win[3][1];
    assign pix18 = win[3][2];
    assign pix19 = win[3][3];
    assign pix20 = win[3][4];
    assign pix21 = win[4][0];
    assign pix22 = win[4][1];
    assign pix23 = win[4][2];
    assign pix24 = win[4][3];
    assign pix25 = win[4][4];

endmodule

// File: tb/tb_window5x5_gen.sv
// Bench for window5x5_gen on an 8x8 image against a frame-array reference model.
module tb_window5x5_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pv;
    logic       sof;
    logic [7:0] pin;
    logic [7:0] p [25];
    logic       wv;
    logic [2:0] wr;
    logic [2:0] wc;

    always #5 clk = ~clk;

    window5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .pix_in(pin), .pix_valid(pv), .sof(sof),
        .pix1(p[0]),   .pix2(p[1]),   .pix3(p[2]),   .pix4(p[3]),   .pix5(p[4]),
        .pix6(p[5]),   .pix7(p[6]),   .pix8(p[7]),   .pix9(p[8]),   .pix10(p[9]),
        .pix11(p[10]), .pix12(p[11]), .pix13(p[12]), .pix14(p[13]), .pix15(p[14]),
        .pix16(p[15]), .pix17(p[16]), .pix18(p[17]), .pix19(p[18]), .pix20(p[19]),
        .pix21(p[20]), .pix22(p[21]), .pix23(p[22]), .pix24(p[23]), .pix25(p[24]),
        .win_valid(wv), .win_row(wr), .win_col(wc)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: the image as written so far, plus the raster position.
    logic [7:0] img [H][W];
    int         mr, mc;
    bit         ev;
    logic [7:0] et [25];
    int         er, ec;
    logic [205:0] ref_q [$];

    function automatic void model_accept(input logic [7:0] v, input bit s);
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        er = mr;
        ec = mc;
        ev = (mr >= 4) && (mc >= 4);
        if (ev) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    et[i*5+j] = img[mr-4+i][mc-4+j];
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endfunction

    function automatic logic [205:0] pack_obs();
        logic [205:0] v;
        for (int k = 0; k < 25; k++) v[k*8 +: 8] = p[k];
        v[205:200] = {wr, wc};
        return v;
    endfunction

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit s);
        pv  = v;
        pin = d;
        sof = s;
        if (v) model_accept(d, s);
        else   ev = 0;
        @(posedge clk);
        #1;
        pv  = 1'b0;
        sof = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; pv = 1'b0; sof = 1'b0; pin = '0;
        mr = 0; mc = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wv !== 1'b0 || wr !== 3'd0 || wc !== 3'd0)
            $display("FAIL reset_status: got v=%b r=%0d c=%0d, want 0 0 0", wv, wr, wc);
        else passed++;
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (p[k] !== 8'd0) $display("FAIL reset_tap%0d: got %0d want 0", k + 1, p[k]);
            else passed++;
        end
        rst = 1'b0;
        #2;
    endtask

    task automatic test_ramp(input bit record, input bit const_chk);
        int pulses = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 8'(8*r + c), (r == 0 && c == 0));
                checks++;
                if (wv !== ev || wr !== 3'(er) || wc !== 3'(ec))
                    $display("FAIL ramp_status (%0d,%0d): got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                             r, c, wv, wr, wc, ev, er, ec);
                else passed++;
                if (ev) begin
                    pulses++;
                    if (record) ref_q.push_back(pack_obs());
                    for (int k = 0; k < 25; k++) begin
                        checks++;
                        if (p[k] !== et[k])
                            $display("FAIL ramp_tap%0d (%0d,%0d): got %0d want %0d", k + 1, r, c, p[k], et[k]);
                        else passed++;
                    end
                end
                if (const_chk && r == 4 && c == 4) begin
                    checks++;
                    if (p[0] !== 8'd0 || p[4] !== 8'd4 || p[12] !== 8'd18 || p[20] !== 8'd32 ||
                        p[24] !== 8'd36 || wr !== 3'd4 || wc !== 3'd4 || wv !== 1'b1)
                        $display("FAIL first_window: got p1=%0d p5=%0d p13=%0d p21=%0d p25=%0d r=%0d c=%0d v=%b want 0 4 18 32 36 4 4 1",
                                 p[0], p[4], p[12], p[20], p[24], wr, wc, wv);
                    else passed++;
                end
            end
        end
        checks++;
        if (pulses != 16) $display("FAIL ramp_pulses: got %0d want 16", pulses);
        else passed++;
        checks++;
        if (p[0] !== 8'd27 || p[24] !== 8'd63 || wr !== 3'd7 || wc !== 3'd7)
            $display("FAIL last_window: got p1=%0d p25=%0d r=%0d c=%0d want 27 63 7 7", p[0], p[24], wr, wc);
        else passed++;
    endtask

    task automatic test_gaps();
        int idx = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(0, 99) < 40) begin
                    step(1'b0, 8'($urandom), 1'($urandom));
                    checks++;
                    if (wv !== 1'b0) $display("FAIL gap_valid (%0d,%0d): got %b want 0", r, c, wv);
                    else passed++;
                end
                step(1'b1, 8'(8*r + c), (r == 0 && c == 0));
                checks++;
                if (wv !== ev) $display("FAIL gaps_valid (%0d,%0d): got %b want %b", r, c, wv, ev);
                else passed++;
                if (ev) begin
                    checks++;
                    if (idx >= ref_q.size() || pack_obs() !== ref_q[idx])
                        $display("FAIL gaps_window%0d: got %h want %h", idx, pack_obs(),
                                 (idx < ref_q.size()) ? ref_q[idx] : 206'd0);
                    else passed++;
                    idx++;
                end
            end
        end
        checks++;
        if (idx != 16) $display("FAIL gaps_pulses: got %0d want 16", idx);
        else passed++;
    endtask

    task automatic test_mid_sof();
        int pulses = 0;
        int first_r = -1, first_c = -1;
        for (int n = 0; n < 2*W + 3; n++) begin
            step(1'b1, 8'(n), (n == 0));
            checks++;
            if (wv !== 1'b0) $display("FAIL abort_prefix_valid n=%0d: got %b want 0", n, wv);
            else passed++;
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 8'($urandom), (r == 0 && c == 0));
                checks++;
                if (wv !== ev || wr !== 3'(er) || wc !== 3'(ec))
                    $display("FAIL sof_status (%0d,%0d): got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                             r, c, wv, wr, wc, ev, er, ec);
                else passed++;
                if (wv === 1'b1) begin
                    pulses++;
                    if (first_r < 0) begin first_r = r; first_c = c; end
                end
                if (ev) begin
                    for (int k = 0; k < 25; k++) begin
                        checks++;
                        if (p[k] !== et[k])
                            $display("FAIL sof_tap%0d (%0d,%0d): got %0d want %0d", k + 1, r, c, p[k], et[k]);
                        else passed++;
                    end
                end
            end
        end
        checks++;
        if (pulses != 16 || first_r != 4 || first_c != 4)
            $display("FAIL sof_first: got pulses=%0d first=(%0d,%0d) want 16 (4,4)", pulses, first_r, first_c);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int n = 0; n <= 5*W + 5; n++) step(1'b1, 8'(n), (n == 0));
        checks++;
        if (wv !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", wv);
        else passed++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wv !== 1'b0 || wr !== 3'd0 || wc !== 3'd0)
            $display("FAIL async_reset_status: got v=%b r=%0d c=%0d want 0 0 0", wv, wr, wc);
        else passed++;
        for (int k = 0; k < 25; k++) begin
            checks++;
            if (p[k] !== 8'd0) $display("FAIL async_reset_tap%0d: got %0d want 0", k + 1, p[k]);
            else passed++;
        end
        @(posedge clk);
        #1 rst = 1'b0;
        mr = 0; mc = 0;
        test_ramp(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int early = 0;
        bit first_seen = 0;
        test_ramp(1'b0, 1'b0);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 8'(255 - (8*r + c)), 1'b0);
                checks++;
                if (wv !== ev || wr !== 3'(er) || wc !== 3'(ec))
                    $display("FAIL b2b_status (%0d,%0d): got v=%b r=%0d c=%0d want v=%b r=%0d c=%0d",
                             r, c, wv, wr, wc, ev, er, ec);
                else passed++;
                if (r < 4 && wv === 1'b1) early++;
                if (ev) begin
                    for (int k = 0; k < 25; k++) begin
                        checks++;
                        if (p[k] !== et[k])
                            $display("FAIL b2b_tap%0d (%0d,%0d): got %0d want %0d", k + 1, r, c, p[k], et[k]);
                        else passed++;
                    end
                end
                if (!first_seen && r == 4 && c == 4) begin
                    first_seen = 1;
                    checks++;
                    if (p[0] !== 8'd255 || p[24] !== 8'd219 || wv !== 1'b1)
                        $display("FAIL b2b_first_window: got p1=%0d p25=%0d v=%b want 255 219 1", p[0], p[24], wv);
                    else passed++;
                end
            end
        end
        checks++;
        if (early != 0) $display("FAIL b2b_early_valid: got %0d want 0", early);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ramp(1'b1, 1'b1);
        test_gaps();
        test_mid_sof();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/window5x5_gen.md
Name: window5x5_gen

Overview:
- Producer side of the 5×5 median datapath.
- Converts a raster-order 8-bit pixel stream into the 25 parallel window taps (pix1..pix25) that the 5×5 recursive median top consumes each clock.
- Holds four previous image lines in line buffers and a 5×5 register window.
- Flags when the window is fully populated with valid in-frame pixels.

Parameters:
- IMG_WIDTH, 640, pixels per line (≥5).
- IMG_HEIGHT, 480, lines per frame (≥5).
- DATA_W, 8, pixel width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pix_in  input  DATA_W  incoming raster pixel.
- pix_valid  input  1  pix_in is accepted this cycle.
- sof  input  1  start of frame, qualified by pix_valid; marks pix_in as pixel (row 0, col 0).
- pix1..pix25  output  DATA_W each  window taps, row-major: pix1..pix5 are the oldest row, pix21..pix25 the newest row; within a row, lower index is the older column.
- win_valid  output  1  taps form a complete in-frame 5×5 window.
- win_row  output  log2(IMG_HEIGHT)  row of pix25.
- win_col  output  log2(IMG_WIDTH)  column of pix25.

Behaviour:
- Reset (async, any time including mid-frame):
  - row/col counters = 0; all window registers = 0; win_valid = 0; win_row = win_col = 0.
  - Line-buffer RAM contents are not reset; rows 0–3 are masked by the valid logic instead.
- Accepted pixel at (r, c), i.e. pix_valid=1:
  - Each line buffer k (k=0..3) reads its location c before writing it, so the chain shifts: lb0[c] ← pix_in, lb(k+1)[c] ← old lb(k)[c].
  - The new window column {old lb3[c], old lb2[c], old lb1[c], old lb0[c], pix_in} is shifted in on the right (newest) column of the 5×5 register array; every row shifts left by one.
- Latency: taps, win_row/win_col and win_valid update on the edge that accepts the pixel; they are visible the cycle after pix_valid.
- Resulting tap mapping: pix25 = P(r,c), pix21 = P(r,c−4), pix5 = P(r−4,c), pix1 = P(r−4,c−4), pix13 = P(r−2,c−2).
- win_valid = 1 for exactly one cycle per accepted pixel with r ≥ 4 and c ≥ 4; it is 0 otherwise.
  - Columns c < 4 straddle the line wrap and are never flagged valid.
- pix_valid = 0: counters, window, RAM and win_row/col hold; win_valid = 0 the next cycle.
- Counters:
  - col increments per accepted pixel and wraps at IMG_WIDTH−1 → 0, which increments row.
  - row wraps at IMG_HEIGHT−1 → 0, so back-to-back frames need no sof.
- sof && pix_valid: that pixel is forced to (0,0) regardless of counter state. The next pixel is (0,1).
  - A mid-frame sof aborts the current frame; no win_valid until the new frame's row 4, col 4.
- sof without pix_valid: ignored.
- Line buffers: one simple dual-port RAM (or 4×) of IMG_WIDTH×DATA_W; read-before-write on the same address in the same cycle is required.
- Implementation size: no arithmetic beyond counters and compares; target 150–250 lines.

Test Plan:
- Ramp frame, W=8, H=8, P(r,c)=8r+c, pix_valid continuous, sof on first pixel → first win_valid the cycle after the 37th pixel (r=4,c=4), with pix1=0, pix5=4, pix13=18, pix21=32, pix25=36, win_row=4, win_col=4.
- Same frame, count win_valid pulses → exactly 16 (4 per row, rows 4–7). Last window: pix1=27, pix25=63, win_row=7, win_col=7.
- Same frame with pix_valid randomly deasserted ~40% → identical sequence of (taps, win_row, win_col) on win_valid cycles as the continuous run; win_valid never high in a cycle following pix_valid=0.
- sof asserted again at pixel (2,3) of the ramp, then a fresh 8×8 frame → no win_valid until new (4,4); taps then match the new frame only.
- rst pulsed asynchronously mid-row 5 → win_valid and all taps 0 immediately. A following frame with sof reproduces the results of the first scenario exactly.
- Two frames back-to-back, second frame P=255−(8r+c), no second sof → second frame rows 0–3 produce no win_valid; first window of the second frame has pix1=255, pix25=219.
